// File: rtl/int_block_matrix_multiplier_if.sv
// int_block_matrix_multiplier_if: start/operand/result bundle (start, i_a, i_b -> o_c, done, busy, ovf)
interface int_block_matrix_multiplier_if #(
  parameter int W = 8,
  parameter int N = 2
);
  logic start;
  logic [N*N*W-1:0] i_a;
  logic [N*N*W-1:0] i_b;
  logic [N*N*W-1:0] o_c;
  logic done;
  logic busy;
  logic ovf;
  modport master(output start, i_a, i_b, input o_c, done, busy, ovf);
  modport slave(input start, i_a, i_b, output o_c, done, busy, ovf);
endinterface

// File: rtl/int_block_matrix_multiplier.sv
// int_block_matrix_multiplier: N x N C=A*B, one row per N cycles on N MAC lanes; clk, rst, bus.slave (start,i_a,i_b in; o_c,done,busy,ovf out)
module int_block_matrix_multiplier #(
  parameter int W = 8,
  parameter int N = 2,
  parameter bit SIGNED = 1'b0,
  parameter bit SAT = 1'b0
) (
  input logic clk,
  input logic rst,
  int_block_matrix_multiplier_if.slave bus
);
  localparam int AW = 2*W + $clog2(N) + 1;
  localparam int IW = $clog2(N);
  localparam logic signed [AW-1:0] HI = SIGNED ? (AW'(1) << (W-1)) - AW'(1) : (AW'(1) << W) - AW'(1);
  localparam logic signed [AW-1:0] LO = SIGNED ? -(AW'(1) << (W-1)) : '0;
  typedef enum logic {IDLE, CALC} state_t;
  state_t state;
  logic [N*N*W-1:0] a_r, b_r, c_r;
  logic [IW-1:0] i, k;
  logic done_r, busy_r, ovf_r;
  logic signed [AW-1:0] acc [N];
  logic signed [AW-1:0] sum [N];
  logic [W-1:0] cv [N];
  logic [N-1:0] of;
  logic signed [AW-1:0] a_e;
  function automatic logic signed [AW-1:0] ext(input logic [W-1:0] x);
    return SIGNED ? AW'(signed'(x)) : AW'(x);
  endfunction
  always_comb begin
    a_e = ext(a_r[(i*N+k)*W +: W]);
    for (int j = 0; j < N; j++) begin
      sum[j] = acc[j] + a_e * ext(b_r[(k*N+j)*W +: W]);
      of[j] = (sum[j] > HI) || (sum[j] < LO);
      cv[j] = !SAT ? sum[j][W-1:0] : sum[j] > HI ? HI[W-1:0] : sum[j] < LO ? LO[W-1:0] : sum[j][W-1:0];
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      a_r <= '0;
      b_r <= '0;
      c_r <= '0;
      i <= '0;
      k <= '0;
      done_r <= 1'b0;
      busy_r <= 1'b0;
      ovf_r <= 1'b0;
      for (int j = 0; j < N; j++) acc[j] <= '0;
    end else begin
      done_r <= 1'b0;
      if (state == IDLE) begin
        if (bus.start) begin
          a_r <= bus.i_a;
          b_r <= bus.i_b;
          i <= '0;
          k <= '0;
          ovf_r <= 1'b0;
          busy_r <= 1'b1;
          state <= CALC;
          for (int j = 0; j < N; j++) acc[j] <= '0;
        end
      end else if (k == IW'(N-1)) begin
        for (int j = 0; j < N; j++) begin
          c_r[(i*N+j)*W +: W] <= cv[j];
          acc[j] <= '0;
        end
        if (|of) ovf_r <= 1'b1;
        k <= '0;
        if (i == IW'(N-1)) begin
          i <= '0;
          done_r <= 1'b1;
          busy_r <= 1'b0;
          state <= IDLE;
        end else begin
          i <= i + 1'b1;
        end
      end else begin
        for (int j = 0; j < N; j++) acc[j] <= sum[j];
        k <= k + 1'b1;
      end
    end
  end
  assign bus.o_c = c_r;
  assign bus.done = done_r;
  assign bus.busy = busy_r;
  assign bus.ovf = ovf_r;
endmodule

// File: tb/tb_int_block_matrix_multiplier.sv
// tb_int_block_matrix_multiplier: scoreboard bench over four configurations of the multiplier
module tb_int_block_matrix_multiplier;
  typedef struct packed {logic [143:0] c; logic ovf;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int total = 0;
  int bad = 0;
  int cw[4] = '{8, 8, 8, 16};
  int cn[4] = '{2, 2, 2, 3};
  bit csg[4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  bit cst[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
  exp_t q0[$], q1[$], q2[$], q3[$];
  exp_t me;
  int ma[9], mb[9], mc[9];
  logic [143:0] a, b, a2, b2;

  int_block_matrix_multiplier_if #(.W(8), .N(2)) f0();
  int_block_matrix_multiplier_if #(.W(8), .N(2)) f1();
  int_block_matrix_multiplier_if #(.W(8), .N(2)) f2();
  int_block_matrix_multiplier_if #(.W(16), .N(3)) f3();
  int_block_matrix_multiplier #(.W(8), .N(2), .SIGNED(1'b0), .SAT(1'b0)) u0(.clk(clk), .rst(rst), .bus(f0.slave));
  int_block_matrix_multiplier #(.W(8), .N(2), .SIGNED(1'b1), .SAT(1'b1)) u1(.clk(clk), .rst(rst), .bus(f1.slave));
  int_block_matrix_multiplier #(.W(8), .N(2), .SIGNED(1'b0), .SAT(1'b1)) u2(.clk(clk), .rst(rst), .bus(f2.slave));
  int_block_matrix_multiplier #(.W(16), .N(3), .SIGNED(1'b1), .SAT(1'b0)) u3(.clk(clk), .rst(rst), .bus(f3.slave));

  function automatic logic [143:0] pk(int d, int m[9]);
    logic [143:0] r = '0;
    for (int e = 0; e < cn[d]*cn[d]; e++)
      for (int x = 0; x < cw[d]; x++) r[e*cw[d]+x] = m[e][x];
    return r;
  endfunction

  function automatic longint el(int d, logic [143:0] v, int e);
    longint x = 0;
    for (int t = 0; t < cw[d]; t++) x[t] = v[e*cw[d]+t];
    if (csg[d] && x[cw[d]-1]) x -= longint'(1) << cw[d];
    return x;
  endfunction

  // Plain integer matrix product followed by range conversion.
  function automatic exp_t model(int d, logic [143:0] x, logic [143:0] y);
    exp_t e;
    int n = cn[d];
    int w = cw[d];
    longint lo, hi, s, v;
    e.c = '0;
    e.ovf = 1'b0;
    lo = csg[d] ? -(longint'(1) << (w-1)) : 0;
    hi = csg[d] ? (longint'(1) << (w-1)) - 1 : (longint'(1) << w) - 1;
    for (int r = 0; r < n; r++)
      for (int c = 0; c < n; c++) begin
        s = 0;
        for (int k = 0; k < n; k++) s += el(d, x, r*n+k) * el(d, y, k*n+c);
        if (s < lo || s > hi) e.ovf = 1'b1;
        v = !cst[d] ? s : (s < lo ? lo : (s > hi ? hi : s));
        for (int t = 0; t < w; t++) e.c[(r*n+c)*w+t] = v[t];
      end
    return e;
  endfunction

  function automatic logic [143:0] rnd();
    logic [143:0] r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return ($urandom_range(3) == 0) ? '1 : r;
  endfunction

  function automatic logic [2:0] flags(int d);
    case (d)
      0: return {f0.done, f0.busy, f0.ovf};
      1: return {f1.done, f1.busy, f1.ovf};
      2: return {f2.done, f2.busy, f2.ovf};
      default: return {f3.done, f3.busy, f3.ovf};
    endcase
  endfunction

  function automatic logic [143:0] outc(int d);
    case (d)
      0: return 144'(f0.o_c);
      1: return 144'(f1.o_c);
      2: return 144'(f2.o_c);
      default: return f3.o_c;
    endcase
  endfunction

  function automatic int qsize(int d);
    case (d)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic void push(int d, exp_t e);
    case (d)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic exp_t qpop(int d);
    case (d)
      0: return q0.pop_front();
      1: return q1.pop_front();
      2: return q2.pop_front();
      default: return q3.pop_front();
    endcase
  endfunction

  task automatic drive(int d, logic s, logic [143:0] x, logic [143:0] y);
    case (d)
      0: begin f0.start = s; f0.i_a = x[31:0]; f0.i_b = y[31:0]; end
      1: begin f1.start = s; f1.i_a = x[31:0]; f1.i_b = y[31:0]; end
      2: begin f2.start = s; f2.i_a = x[31:0]; f2.i_b = y[31:0]; end
      default: begin f3.start = s; f3.i_a = x; f3.i_b = y; end
    endcase
  endtask

  task automatic chk(string nm, logic [143:0] act, logic [143:0] ex);
    total++;
    if (act !== ex) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, ex);
    end
  endtask

  task automatic issue(int d, logic [143:0] x, logic [143:0] y);
    push(d, model(d, x, y));
    drive(d, 1'b1, x, y);
    @(negedge clk);
    drive(d, 1'b0, rnd(), rnd());
  endtask

  // Checks busy/done cycle by cycle; c counts edges after the accept edge.
  task automatic run_timed(int d, logic [143:0] x, logic [143:0] y);
    int n2 = cn[d]*cn[d];
    push(d, model(d, x, y));
    drive(d, 1'b1, x, y);
    for (int c = 0; c <= n2; c++) begin
      @(negedge clk);
      if (c == 0) drive(d, 1'b0, rnd(), rnd());
      chk($sformatf("done_d%0d_c%0d", d, c), flags(d)[2], c == n2);
      chk($sformatf("busy_d%0d_c%0d", d, c), flags(d)[1], c < n2);
    end
  endtask

  task automatic wait_idle(int d);
    for (int t = 0; t < 80 && qsize(d) > 0; t++) @(negedge clk);
    if (qsize(d) > 0) begin
      total++;
      bad++;
      $display("FAIL timeout_d%0d pending=%0d want=0", d, qsize(d));
      while (qsize(d) > 0) void'(qpop(d));
    end
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) if (flags(d)[2] === 1'b1) begin
      if (qsize(d) == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done_d%0d got=1 want=0", d);
      end else begin
        me = qpop(d);
        chk($sformatf("c_d%0d", d), outc(d), me.c);
        chk($sformatf("ovf_d%0d", d), flags(d)[0], me.ovf);
        chk($sformatf("busy_at_done_d%0d", d), flags(d)[1], 1'b0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=running want=finished");
    $fatal(1);
  end

  initial begin
    for (int d = 0; d < 4; d++) drive(d, 1'b0, '0, '0);
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("reset_flags_d%0d", d), flags(d), 3'b000);
      chk($sformatf("reset_c_d%0d", d), outc(d), '0);
    end
    rst = 1'b0;
    @(negedge clk);
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_timed(0, pk(0, ma), pk(0, mb));
    wait_idle(0);
    mc = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
    chk("plan1_c", outc(0), pk(0, mc));
    chk("plan1_ovf", flags(0)[0], 1'b0);
    ma = '{default: 100};
    issue(1, pk(1, ma), pk(1, ma));
    wait_idle(1);
    mc = '{default: 127};
    chk("sat_pos_c", outc(1), pk(1, mc));
    chk("sat_pos_ovf", flags(1)[0], 1'b1);
    ma = '{-3, 2, 1, -1, 0, 0, 0, 0, 0};
    mb = '{4, 0, -5, 7, 0, 0, 0, 0, 0};
    issue(1, pk(1, ma), pk(1, mb));
    wait_idle(1);
    mc = '{-22, 14, 9, -7, 0, 0, 0, 0, 0};
    chk("signed_c", outc(1), pk(1, mc));
    chk("signed_ovf", flags(1)[0], 1'b0);
    ma = '{16, 0, 0, 0, 0, 0, 0, 0, 0};
    issue(0, pk(0, ma), pk(0, ma));
    wait_idle(0);
    chk("wrap_c", outc(0), '0);
    chk("wrap_ovf", flags(0)[0], 1'b1);
    issue(2, pk(2, ma), pk(2, ma));
    wait_idle(2);
    mc = '{255, 0, 0, 0, 0, 0, 0, 0, 0};
    chk("usat_c", outc(2), pk(2, mc));
    chk("usat_ovf", flags(2)[0], 1'b1);
    ma = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    mb = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    run_timed(3, pk(3, ma), pk(3, mb));
    wait_idle(3);
    chk("ident_c", outc(3), pk(3, mb));
    // start held during busy must be ignored
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    a = pk(0, ma);
    b = pk(0, mb);
    push(0, model(0, a, b));
    drive(0, 1'b1, a, b);
    @(negedge clk);
    drive(0, 1'b1, '1, '1);
    repeat (2) @(negedge clk);
    drive(0, 1'b0, '0, '0);
    wait_idle(0);
    repeat (8) @(negedge clk);
    chk("ignore_busy", flags(0)[1], 1'b0);
    // back-to-back: start held through the done cycle
    ma = '{2, 1, 1, 2, 0, 0, 0, 0, 0};
    a2 = pk(0, ma);
    b2 = b;
    push(0, model(0, a, b));
    push(0, model(0, a2, b2));
    drive(0, 1'b1, a, b);
    for (int c = 0; c <= 9; c++) begin
      @(negedge clk);
      chk($sformatf("b2b_done_c%0d", c), flags(0)[2], c == 4 || c == 9);
      if (c == 4) drive(0, 1'b1, a2, b2);
      if (c == 5) drive(0, 1'b0, rnd(), rnd());
    end
    wait_idle(0);
    // reset at edge 2 must win over the row-0 write and its overflow
    ma = '{16, 3, 3, 3, 0, 0, 0, 0, 0};
    drive(0, 1'b1, pk(0, ma), pk(0, ma));
    @(negedge clk);
    drive(0, 1'b0, '0, '0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_flags", flags(0), 3'b000);
    chk("rst_mid_c", outc(0), '0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("rst_mid_idle", flags(0), 3'b000);
    ma = '{1, 2, 3, 4, 0, 0, 0, 0, 0};
    mb = '{5, 6, 7, 8, 0, 0, 0, 0, 0};
    run_timed(0, pk(0, ma), pk(0, mb));
    wait_idle(0);
    mc = '{19, 22, 43, 50, 0, 0, 0, 0, 0};
    chk("after_rst_c", outc(0), pk(0, mc));
    for (int r = 0; r < 12; r++)
      for (int d = 0; d < 4; d++) begin
        a = rnd();
        b = rnd();
        issue(d, a, b);
        wait_idle(d);
      end
    for (int d = 0; d < 4; d++) chk($sformatf("left_d%0d", d), qsize(d), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
